gpio_pad_ctrl: RTL and testbench
================================

# gpio_pad_ctrl

Core-side control stage for one sky130 GPIOv2 pad. It sequences the pad's high-voltage enable pins from power-good through to operational mode, and drives the pad's hold pin. It also conditions the pad's `IN` output into a synchronized, debounced level with edge pulses for core logic. One instance sits directly upstream of each `sky130_fd_io__top_gpiov2` enable/hold input and directly downstream of its `IN` output.

## Interface
Parameters:
- `SEQ_STEP_CYCLES`, default 16: cycles spent in each power-up step; legal range 1..2^CNT_W-1.
- `DEBOUNCE_CYCLES`, default 8: consecutive stable synchronized cycles required to accept an input change; legal range 1..2^CNT_W-1.
- `CNT_W`, default 8: width of the step counter and the debounce counter.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `pwr_good`  in  1  supply-good indication, level.
- `hold_req`  in  1  core request to freeze the pad state, level.
- `pad_in`  in  1  pad `IN` output; asynchronous to `clk`.
- `enable_vddio`  out  1  to pad `ENABLE_VDDIO`.
- `enable_vdda_h`  out  1  to pad `ENABLE_VDDA_H`.
- `enable_h`  out  1  to pad `ENABLE_H`.
- `enable_vswitch_h`  out  1  to pad `ENABLE_VSWITCH_H`.
- `enable_inp_h`  out  1  to pad `ENABLE_INP_H`.
- `hold_h`  out  1  to pad `HOLD_H`; 0 means held/latched, 1 means transparent.
- `ready`  out  1  pad is operational, meaning state RUN.
- `in_sync`  out  1  debounced pad input level.
- `in_rise`  out  1  one-cycle pulse on a debounced 0→1 change.
- `in_fall`  out  1  one-cycle pulse on a debounced 1→0 change.

## Operation
- All outputs are registered.
- Reset value of every output is 0, so the pad is held during reset.
- FSM states: OFF, VDDIO, ENH, INP, RUN, HOLD.
- Outputs are a pure registered decode of the state:
  - OFF: all enables 0, `hold_h`=0.
  - VDDIO: `enable_vddio`=1, `enable_vdda_h`=1.
  - ENH: VDDIO outputs plus `enable_h`=1 and `enable_vswitch_h`=1.
  - INP: ENH outputs plus `enable_inp_h`=1.
  - RUN: all enables 1, `hold_h`=1, `ready`=1.
  - HOLD: all enables 1, `hold_h`=0, `ready`=0.
- Transitions:
  - OFF→VDDIO when `pwr_good`=1.
  - VDDIO→ENH, ENH→INP and INP→RUN each occur after exactly SEQ_STEP_CYCLES cycles in the state. The step counter loads SEQ_STEP_CYCLES-1 on entry and advances the state when it reads 0.
  - RUN→HOLD when `hold_req`=1.
  - HOLD→RUN when `hold_req`=0.
  - Any state→OFF when `pwr_good`=0. This has priority over every other transition and clears the step counter.
- `hold_req` is ignored outside RUN and HOLD.
- Input path:
  - A two-flop synchronizer on `pad_in` feeds the debouncer.
  - The debounce counter increments while the synchronized value differs from `in_sync`, and clears whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, `in_sync` takes the new value, the counter clears, and exactly one of `in_rise`/`in_fall` pulses for one cycle.
- The input path is active only in RUN and HOLD. In all other states, the synchronizer flops, the debounce counter, `in_sync` and the pulses are forced to 0.

## Timing
- With `pwr_good` first sampled 1 at edge k in OFF:
  - `enable_vddio` and `enable_vdda_h` are high after edge k.
  - `enable_h` and `enable_vswitch_h` are high after edge k+N.
  - `enable_inp_h` is high after edge k+2N.
  - `hold_h` and `ready` are high after edge k+3N.
  - N = SEQ_STEP_CYCLES.
- `pwr_good` sampled 0 at edge j: all outputs are 0 after edge j, from any state, including mid-step.
- `hold_req` has one cycle of latency in both directions between RUN and HOLD.
- A clean `pad_in` change, stable from edge m, gives an `in_sync` change and its edge pulse after edge m+1+DEBOUNCE_CYCLES:
  - 2 cycles of synchronizer delay.
  - DEBOUNCE_CYCLES stable cycles at the synchronizer output.
- A glitch shorter than DEBOUNCE_CYCLES cycles at the synchronizer output produces no change and no pulse.
- A change that reverts on the same edge the counter would reach threshold is rejected, because the counter clears on the match.
- `rst` asserted mid-sequence or in RUN: all outputs are 0 on the next cycle and the FSM is in OFF.
  - If `pwr_good` is still 1 when `rst` drops, the full sequence restarts from VDDIO.

## Test plan
- Power-up, N=4: raise `pwr_good` at edge 10 → enables step at edges 10/14/18, and `ready`=`hold_h`=1 from edge 22.
- Brown-out: drop `pwr_good` in ENH at edge 15 → all outputs 0 after edge 15. Re-raise it → the sequence restarts with full step lengths.
- Hold: in RUN, pulse `hold_req` high for 5 cycles → `hold_h`=0 and `ready`=0 for 5 cycles starting one cycle later, with all enables remaining 1.
- Debounce, DEBOUNCE_CYCLES=8: `pad_in` 0→1 held → `in_sync`=1 and a single `in_rise` pulse 9 edges after the change. A 5-cycle high glitch → no `in_sync` change and no pulse.
- Input gating: toggle `pad_in` before RUN → `in_sync`, `in_rise` and `in_fall` stay 0. Then toggle a high level in RUN → a normal `in_rise` pulse.
- `rst` asserted in RUN with `in_sync`=1 → all outputs 0 next cycle, no `in_fall` pulse, then a re-sequence after `rst` is released.

Source files
------------

// File: rtl/gpio_pad_ctrl_if.sv
// Pad-side signal bundle for one sky130 GPIOv2 pad control stage.
interface gpio_pad_ctrl_if;
    logic pwr_good;
    logic hold_req;
    logic pad_in;
    logic enable_vddio;
    logic enable_vdda_h;
    logic enable_h;
    logic enable_vswitch_h;
    logic enable_inp_h;
    logic hold_h;
    logic ready;
    logic in_sync;
    logic in_rise;
    logic in_fall;

    // Core / stimulus side: drives power, hold and pad input.
    modport master (
        output pwr_good,
        output hold_req,
        output pad_in,
        input  enable_vddio,
        input  enable_vdda_h,
        input  enable_h,
        input  enable_vswitch_h,
        input  enable_inp_h,
        input  hold_h,
        input  ready,
        input  in_sync,
        input  in_rise,
        input  in_fall
    );

    // Controller side: drives the pad enables and the conditioned input.
    modport slave (
        input  pwr_good,
        input  hold_req,
        input  pad_in,
        output enable_vddio,
        output enable_vdda_h,
        output enable_h,
        output enable_vswitch_h,
        output enable_inp_h,
        output hold_h,
        output ready,
        output in_sync,
        output in_rise,
        output in_fall
    );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// Power-up sequencer, hold control and input conditioner for one GPIOv2 pad.
module gpio_pad_ctrl #(
    parameter int unsigned SEQ_STEP_CYCLES = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    gpio_pad_ctrl_if.slave   pad_if
);

    localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(SEQ_STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_VDDIO = 3'd1,
        ST_ENH   = 3'd2,
        ST_INP   = 3'd3,
        ST_RUN   = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_step_cnt;
    logic [CNT_W-1:0] w_step_cnt_nxt;

    logic r_enable_vddio;
    logic r_enable_vdda_h;
    logic r_enable_h;
    logic r_enable_vswitch_h;
    logic r_enable_inp_h;
    logic r_hold_h;
    logic r_ready;

    logic w_enable_vddio;
    logic w_enable_vdda_h;
    logic w_enable_h;
    logic w_enable_vswitch_h;
    logic w_enable_inp_h;
    logic w_hold_h;
    logic w_ready;

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_deb_cnt;
    logic [CNT_W-1:0] w_deb_cnt_inc;
    logic             r_in_sync;
    logic             r_in_rise;
    logic             r_in_fall;
    logic             w_in_active;

    // State and step counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_OFF;
            r_step_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_step_cnt <= w_step_cnt_nxt;
        end
    end

    // Next state: loss of power-good overrides everything and clears the step count.
    always_comb begin
        w_state_nxt    = r_state;
        w_step_cnt_nxt = r_step_cnt;
        if (!pad_if.pwr_good) begin
            w_state_nxt    = ST_OFF;
            w_step_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt    = ST_VDDIO;
                    w_step_cnt_nxt = STEP_LOAD;
                end
                ST_VDDIO: begin
                    if (r_step_cnt == '0) begin
                        w_state_nxt    = ST_ENH;
                        w_step_cnt_nxt = STEP_LOAD;
                    end else begin
                        w_step_cnt_nxt = r_step_cnt - CNT_W'(1);
                    end
                end
                ST_ENH: begin
                    if (r_step_cnt == '0) begin
                        w_state_nxt    = ST_INP;
                        w_step_cnt_nxt = STEP_LOAD;
                    end else begin
                        w_step_cnt_nxt = r_step_cnt - CNT_W'(1);
                    end
                end
                ST_INP: begin
                    if (r_step_cnt == '0) begin
                        w_state_nxt    = ST_RUN;
                        w_step_cnt_nxt = '0;
                    end else begin
                        w_step_cnt_nxt = r_step_cnt - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (pad_if.hold_req) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!pad_if.hold_req) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt    = ST_OFF;
                    w_step_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Pad pin decode of the upcoming state, so pins move on the same edge as the state.
    always_comb begin
        w_enable_vddio     = 1'b0;
        w_enable_vdda_h    = 1'b0;
        w_enable_h         = 1'b0;
        w_enable_vswitch_h = 1'b0;
        w_enable_inp_h     = 1'b0;
        w_hold_h           = 1'b0;
        w_ready            = 1'b0;
        case (w_state_nxt)
            ST_VDDIO: begin
                w_enable_vddio  = 1'b1;
                w_enable_vdda_h = 1'b1;
            end
            ST_ENH: begin
                w_enable_vddio     = 1'b1;
                w_enable_vdda_h    = 1'b1;
                w_enable_h         = 1'b1;
                w_enable_vswitch_h = 1'b1;
            end
            ST_INP: begin
                w_enable_vddio     = 1'b1;
                w_enable_vdda_h    = 1'b1;
                w_enable_h         = 1'b1;
                w_enable_vswitch_h = 1'b1;
                w_enable_inp_h     = 1'b1;
            end
            ST_RUN: begin
                w_enable_vddio     = 1'b1;
                w_enable_vdda_h    = 1'b1;
                w_enable_h         = 1'b1;
                w_enable_vswitch_h = 1'b1;
                w_enable_inp_h     = 1'b1;
                w_hold_h           = 1'b1;
                w_ready            = 1'b1;
            end
            ST_HOLD: begin
                w_enable_vddio     = 1'b1;
                w_enable_vdda_h    = 1'b1;
                w_enable_h         = 1'b1;
                w_enable_vswitch_h = 1'b1;
                w_enable_inp_h     = 1'b1;
            end
            default: begin
                w_hold_h = 1'b0;
            end
        endcase
    end

    // Registered pad pins; reset leaves the pad held with all enables low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable_vddio     <= 1'b0;
            r_enable_vdda_h    <= 1'b0;
            r_enable_h         <= 1'b0;
            r_enable_vswitch_h <= 1'b0;
            r_enable_inp_h     <= 1'b0;
            r_hold_h           <= 1'b0;
            r_ready            <= 1'b0;
        end else begin
            r_enable_vddio     <= w_enable_vddio;
            r_enable_vdda_h    <= w_enable_vdda_h;
            r_enable_h         <= w_enable_h;
            r_enable_vswitch_h <= w_enable_vswitch_h;
            r_enable_inp_h     <= w_enable_inp_h;
            r_hold_h           <= w_hold_h;
            r_ready            <= w_ready;
        end
    end

    assign w_in_active   = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_HOLD);
    assign w_deb_cnt_inc = r_deb_cnt + CNT_W'(1);

    // Synchronizer and debouncer; flushed to 0 whenever the pad is not operational.
    always_ff @(posedge clk) begin
        if (rst || !w_in_active) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_deb_cnt <= '0;
            r_in_sync <= 1'b0;
            r_in_rise <= 1'b0;
            r_in_fall <= 1'b0;
        end else begin
            r_sync1   <= pad_if.pad_in;
            r_sync2   <= r_sync1;
            r_in_rise <= 1'b0;
            r_in_fall <= 1'b0;
            if (r_sync2 != r_in_sync) begin
                if (w_deb_cnt_inc == DEB_LIMIT) begin
                    r_in_sync <= r_sync2;
                    r_deb_cnt <= '0;
                    r_in_rise <= r_sync2;
                    r_in_fall <= ~r_sync2;
                end else begin
                    r_deb_cnt <= w_deb_cnt_inc;
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    assign pad_if.enable_vddio     = r_enable_vddio;
    assign pad_if.enable_vdda_h    = r_enable_vdda_h;
    assign pad_if.enable_h         = r_enable_h;
    assign pad_if.enable_vswitch_h = r_enable_vswitch_h;
    assign pad_if.enable_inp_h     = r_enable_inp_h;
    assign pad_if.hold_h           = r_hold_h;
    assign pad_if.ready            = r_ready;
    assign pad_if.in_sync          = r_in_sync;
    assign pad_if.in_rise          = r_in_rise;
    assign pad_if.in_fall          = r_in_fall;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: directed plan followed by random stimulus, against a timeline model.
module tb_gpio_pad_ctrl;

    localparam int N = 4;
    localparam int D = 8;

    logic clk;
    logic rst;

    gpio_pad_ctrl_if pad_if ();

    gpio_pad_ctrl #(
        .SEQ_STEP_CYCLES (N),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (8)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .pad_if (pad_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Model: m_up counts edges since power-good was accepted (-1 = unpowered).
    int m_up;
    bit m_held;
    bit m_s1, m_s2, m_in_sync, m_rise, m_fall;
    int m_deb;

    task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit pg, input bit hr, input bit pi);
        int prev;
        prev = m_up;
        if (r || !pg)       m_up = -1;
        else if (m_up < 0)  m_up = 0;
        else if (m_up < 3*N) m_up++;
        // hold_req only matters once the pad was already operational before this edge
        m_held = (!r && pg && prev >= 3*N) ? hr : 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (m_up < 3*N) begin
            m_s1 = 0; m_s2 = 0; m_in_sync = 0; m_deb = 0;
        end else begin
            if (m_s2 != m_in_sync) begin
                m_deb++;
                if (m_deb == D) begin
                    m_in_sync = m_s2;
                    m_deb     = 0;
                    m_rise    = m_s2;
                    m_fall    = !m_s2;
                end
            end else begin
                m_deb = 0;
            end
            m_s2 = m_s1;
            m_s1 = pi;
        end
    endtask

    function automatic logic [9:0] model_outs();
        bit run;
        run = (m_up >= 3*N) && !m_held;
        return {m_up >= 0, m_up >= 0, m_up >= N, m_up >= N, m_up >= 2*N,
                run, run, m_in_sync, m_rise, m_fall};
    endfunction

    function automatic logic [9:0] dut_outs();
        return {pad_if.enable_vddio, pad_if.enable_vdda_h, pad_if.enable_h,
                pad_if.enable_vswitch_h, pad_if.enable_inp_h, pad_if.hold_h,
                pad_if.ready, pad_if.in_sync, pad_if.in_rise, pad_if.in_fall};
    endfunction

    // One clock: drive inputs, advance model, check after the edge.
    task automatic cycle(input string tag, input bit r, input bit pg, input bit hr, input bit pi);
        rst             = r;
        pad_if.pwr_good = pg;
        pad_if.hold_req = hr;
        pad_if.pad_in   = pi;
        model_step(r, pg, hr, pi);
        @(negedge clk);
        check_val(tag, dut_outs(), model_outs());
    endtask

    task automatic cycles(input string tag, input int n, input bit r, input bit pg,
                          input bit hr, input bit pi);
        for (int i = 0; i < n; i++) cycle(tag, r, pg, hr, pi);
    endtask

    int pi_run, hr_run, pg_run, rst_run;
    bit r_pi, r_hr, r_pg, r_rst;

    initial begin
        checks = 0;
        errors = 0;
        m_up = -1; m_held = 0; m_s1 = 0; m_s2 = 0; m_in_sync = 0; m_deb = 0;
        m_rise = 0; m_fall = 0;

        cycles("reset", 3, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle("gate_off", 0, 0, 0, bit'(i % 2));
        // brown-out inside ENH
        for (int i = 0; i < 6; i++) cycle("gate_seq", 0, 1, 0, bit'(i % 2));
        cycles("brownout", 2, 0, 0, 0, 1);
        cycles("powerup", 16, 0, 1, 0, 0);
        // debounce: clean rise, low glitch, clean fall, high glitch
        cycles("rise", 14, 0, 1, 0, 1);
        cycles("glitch_lo", 5, 0, 1, 0, 0);
        cycles("settle_hi", 12, 0, 1, 0, 1);
        cycles("fall", 14, 0, 1, 0, 0);
        cycles("glitch_hi", 5, 0, 1, 0, 1);
        cycles("settle_lo", 12, 0, 1, 0, 0);
        // hold pulse
        cycles("hold", 5, 0, 1, 1, 0);
        cycles("unhold", 4, 0, 1, 0, 0);
        // reset while in_sync is high, then re-sequence
        cycles("pre_rst", 14, 0, 1, 0, 1);
        cycles("rst_run", 2, 1, 1, 0, 1);
        cycles("reseq", 20, 0, 1, 0, 1);

        pi_run = 0; hr_run = 0; pg_run = 0; rst_run = 0;
        r_pi = 0; r_hr = 0; r_pg = 1; r_rst = 0;
        for (int i = 0; i < 4000; i++) begin
            if (pi_run == 0) begin r_pi = !r_pi; pi_run = int'($urandom_range(1, 14)); end
            if (hr_run == 0) begin r_hr = !r_hr; hr_run = int'($urandom_range(1, 20)); end
            if (pg_run == 0) begin
                if (!r_pg) begin r_pg = 1; pg_run = int'($urandom_range(30, 300)); end
                else       begin r_pg = 0; pg_run = int'($urandom_range(1, 4)); end
            end
            if (rst_run == 0) begin
                if (r_rst) begin r_rst = 0; rst_run = int'($urandom_range(50, 500)); end
                else       begin r_rst = 1; rst_run = int'($urandom_range(1, 3)); end
            end
            pi_run--; hr_run--; pg_run--; rst_run--;
            cycle("random", r_rst, r_pg, r_hr, r_pi);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
